// File: rtl/ov2640_yuv422_tx.sv
// ov2640_yuv422_tx: DVP-style YUV422 frame transmitter (VSYNC/HREF/DATA, one byte per PCLK).
// Latency: pixel accepted at cycle t -> luma on DATA at t+1, chroma at t+2 (HREF=1 both).
// Backpressure: none; timing free-runs and a missing pixel is replaced by black (0x10/0x80).
// Ports: PCLK/RST_N (sync, active-low); enable; pixel_in/pixel_valid/pixel_ready stream in;
//        VSYNC/HREF/DATA camera byte bus out; frame_done pulse; underflow sticky flag.
module ov2640_yuv422_tx #(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 16,
  parameter int V_ACTIVE  = 480,
  parameter int VSYNC_LEN = 3,
  parameter int V_BACK    = 2,
  parameter int V_FRONT   = 2
) (
  input  logic        PCLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic [15:0] pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  DATA,
  output logic        frame_done,
  output logic        underflow
);

  localparam int H_BYTES = 2 * H_ACTIVE;
  localparam int H_TOTAL = H_BYTES + H_BLANK;
  localparam int V_M0    = (VSYNC_LEN > V_BACK) ? VSYNC_LEN : V_BACK;
  localparam int V_M1    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX   = (V_M0 > V_M1) ? V_M0 : V_M1;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  // r_state/r_hcnt/r_vcnt describe the position whose outputs are on the pins now;
  // the registered outputs are decoded from the next position.
  state_t          r_state, w_nstate;
  logic [HW-1:0]   r_hcnt, w_nhcnt;
  logic [VW-1:0]   r_vcnt, w_nvcnt;
  logic [VW-1:0]   w_last_line;
  logic            w_frame_end;
  logic            w_byte_next;
  logic            w_vsync_d, w_href_d, w_uf_set, w_vs_start;
  logic [7:0]      w_data_d;
  logic [7:0]      r_chroma;
  logic            r_vsync, r_href, r_frame_done, r_underflow;
  logic [7:0]      r_data;

  // State register.
  always_ff @(posedge PCLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
    end else begin
      r_state <= w_nstate;
      r_hcnt  <= w_nhcnt;
      r_vcnt  <= w_nvcnt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_nstate    = r_state;
    w_nhcnt     = r_hcnt;
    w_nvcnt     = r_vcnt;
    w_frame_end = 1'b0;
    case (r_state)
      S_VSYNC:  w_last_line = VW'(VSYNC_LEN - 1);
      S_VBACK:  w_last_line = VW'(V_BACK - 1);
      S_ACTIVE: w_last_line = VW'(V_ACTIVE - 1);
      default:  w_last_line = VW'(V_FRONT - 1);
    endcase
    if (r_state == S_IDLE) begin
      if (enable) begin
        w_nstate = S_VSYNC;
        w_nhcnt  = '0;
        w_nvcnt  = '0;
      end
    end else if (r_hcnt != HW'(H_TOTAL - 1)) begin
      w_nhcnt = r_hcnt + HW'(1);
    end else begin
      w_nhcnt = '0;
      if (r_vcnt != w_last_line) begin
        w_nvcnt = r_vcnt + VW'(1);
      end else begin
        w_nvcnt = '0;
        case (r_state)
          S_VSYNC:  w_nstate = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
          S_VBACK:  w_nstate = S_ACTIVE;
          S_ACTIVE: begin
            // With no front porch the last active line closes the frame.
            if (V_FRONT > 0) w_nstate = S_VFRONT;
            else             w_frame_end = 1'b1;
          end
          default:  w_frame_end = 1'b1;
        endcase
        if (w_frame_end) w_nstate = enable ? S_VSYNC : S_IDLE;
      end
    end
  end

  // Output decode from the next position; registered below so pins change together.
  always_comb begin
    w_byte_next = (w_nstate == S_ACTIVE) && (w_nhcnt < HW'(H_BYTES));
    pixel_ready = RST_N && w_byte_next && !w_nhcnt[0];
    w_vsync_d   = (w_nstate != S_VSYNC);
    w_href_d    = w_byte_next;
    w_uf_set    = pixel_ready && !pixel_valid;
    w_vs_start  = (w_nstate == S_VSYNC) && (r_state != S_VSYNC);
    w_data_d    = 8'h00;
    if (w_byte_next) begin
      if (!w_nhcnt[0]) w_data_d = pixel_valid ? pixel_in[15:8] : 8'h10;
      else             w_data_d = r_chroma;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!RST_N) begin
      r_vsync      <= 1'b1;
      r_href       <= 1'b0;
      r_data       <= 8'h00;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_chroma     <= 8'h00;
    end else begin
      r_vsync      <= w_vsync_d;
      r_href       <= w_href_d;
      r_data       <= w_data_d;
      r_frame_done <= w_frame_end;
      if (pixel_ready) r_chroma <= pixel_valid ? pixel_in[7:0] : 8'h80;
      // A miss can never coincide with frame start, so clear and set do not collide.
      if (w_vs_start)    r_underflow <= 1'b0;
      else if (w_uf_set) r_underflow <= 1'b1;
    end
  end

  assign VSYNC      = r_vsync;
  assign HREF       = r_href;
  assign DATA       = r_data;
  assign frame_done = r_frame_done;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_ov2640_yuv422_tx.sv
// tb_ov2640_yuv422_tx: checks the DVP transmitter against a frame-position reference model.
// Latency: model predicts every output each PCLK from the cycle index within the frame.
// Backpressure: stimulus drives pixel_valid held, with a forced miss, or random.
module tb_ov2640_yuv422_tx;
  localparam int HA = 4, HB = 3, VA = 2, VS = 1, VBK = 1, VF = 1;
  localparam int HT = 2 * HA + HB;
  localparam int FRAME = (VS + VBK + VA + VF) * HT;

  logic        PCLK = 1'b0;
  logic        RST_N, enable, pixel_valid;
  logic [15:0] pixel_in;
  logic        pixel_ready, VSYNC, HREF, frame_done, underflow;
  logic [7:0]  DATA;

  ov2640_yuv422_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
                     .VSYNC_LEN(VS), .V_BACK(VBK), .V_FRONT(VF)) dut (
    .PCLK(PCLK), .RST_N(RST_N), .enable(enable), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .VSYNC(VSYNC),
    .HREF(HREF), .DATA(DATA), .frame_done(frame_done), .underflow(underflow));

  always #5 PCLK = ~PCLK;

  int          n_assert = 0, n_fail = 0;
  int          pos = -1;          // cycle index within frame of the outputs now shown, -1 = idle
  bit          exp_uf = 1'b0, exp_fd = 1'b0;
  logic [7:0]  q[$];              // bytes promised to the line, in transmit order
  int          slot_cnt = 0, frame_slot = 0, miss_slot = 2, vmode = 0;
  logic [15:0] next_pix = 16'h1080;

  function automatic bit is_byte(int p);
    int line, col;
    if (p < 0) return 1'b0;
    line = p / HT;
    col  = p % HT;
    return (line >= VS + VBK) && (line < VS + VBK + VA) && (col < 2 * HA);
  endfunction

  function automatic bit rdy(int p);
    int nx;
    if (p < 0) return 1'b0;
    nx = (p + 1) % FRAME;
    return is_byte(nx) && ((nx % HT) % 2 == 0);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h pos=%0d", tag, obs, exp, pos);
    end
  endtask

  task automatic cycle();
    bit         exp_rdy, hs, miss, exp_href, exp_vs;
    logic [7:0] exp_data;
    exp_rdy = rdy(pos) && RST_N;
    case (vmode)
      0:       begin pixel_valid = 1'b1; pixel_in = next_pix; end
      1:       begin pixel_valid = ($urandom_range(0, 3) != 0); pixel_in = 16'($urandom); end
      default: begin pixel_valid = (frame_slot != miss_slot); pixel_in = next_pix; end
    endcase
    hs   = exp_rdy && pixel_valid;
    miss = exp_rdy && !pixel_valid;
    if (hs) begin
      q.push_back(pixel_in[15:8]);
      q.push_back(pixel_in[7:0]);
      next_pix = next_pix + 16'h1101;
    end else if (miss) begin
      q.push_back(8'h10);
      q.push_back(8'h80);
    end
    if (exp_rdy) frame_slot++;
    @(posedge PCLK);
    if (!RST_N) begin
      pos = -1; q.delete(); exp_uf = 1'b0; exp_fd = 1'b0; slot_cnt = 0;
    end else begin
      exp_fd = (pos == FRAME - 1);
      if (pos < 0 || pos == FRAME - 1) pos = enable ? 0 : -1;
      else pos++;
      if (pos == 0) exp_uf = 1'b0;
      if (miss) exp_uf = 1'b1;
    end
    #1;
    exp_vs   = (pos < 0) || (pos / HT >= VS);
    exp_href = is_byte(pos);
    exp_data = 8'h00;
    if (exp_href && q.size() > 0) exp_data = q.pop_front();
    chk("vsync", 32'(VSYNC), 32'(exp_vs));
    chk("href", 32'(HREF), 32'(exp_href));
    chk("data", 32'(DATA), 32'(exp_data));
    chk("frame_done", 32'(frame_done), 32'(exp_fd));
    chk("underflow", 32'(underflow), 32'(exp_uf));
    chk("pixel_ready", 32'(pixel_ready), 32'(rdy(pos) && RST_N));
    if (exp_fd) chk("slots_per_frame", 32'(slot_cnt), 32'(2 * HA / 2 * VA));
    if (pos == 0) begin slot_cnt = 0; frame_slot = 0; end
    if (pixel_ready === 1'b1) slot_cnt++;
  endtask

  task automatic run_n(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until(int target, int budget, string tag);
    int n;
    n = 0;
    while (pos != target && n < budget) begin cycle(); n++; end
    n_assert++;
    assert (pos == target) else begin
      n_fail++;
      $error("FAIL %s timeout observed_pos=%0d expected_pos=%0d", tag, pos, target);
    end
  endtask

  initial begin
    RST_N = 1'b0; enable = 1'b0; pixel_valid = 1'b0; pixel_in = 16'h0;
    // Reset, then idle with enable low.
    run_n(3);
    RST_N = 1'b1;
    run_n(3);
    // Back-to-back frames with an always-valid incrementing stream.
    enable = 1'b1;
    run_n(2 * FRAME + 5);
    // Third pixel of the first active line missing.
    run_until(0, 2 * FRAME, "sync_frame_start");
    vmode = 2;
    run_n(FRAME + 3);
    // Random valid pattern and pixel content.
    vmode = 1;
    run_n(5 * FRAME);
    // Drop enable in the middle of an active line; frame must complete, then idle.
    run_until(26, 2 * FRAME, "reach_active");
    enable = 1'b0;
    run_n(FRAME + 10);
    // Reset during an HREF-high byte, then restart.
    enable = 1'b1;
    run_until(27, 2 * FRAME, "reach_byte");
    RST_N = 1'b0;
    cycle();
    RST_N = 1'b1;
    run_n(2 * FRAME + 5);
    enable = 1'b0;
    run_n(FRAME + 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
